// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame instruction cache between the datapath and the memory arbiter.
// Hits answer combinationally; misses fetch one word over the iREN/iwait handshake.
module icache_responder #(
    parameter int unsigned SETS   = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    output logic              ihit,
    output logic [ADDR_W-1:0] imemload,
    output logic              iREN,
    output logic [ADDR_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [ADDR_W-1:0] iload,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [0:0] {StIdle, StFetch} state_t;

    state_t            r_state;
    state_t            w_state_d;
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [ADDR_W-1:0] r_data [SETS];
    logic [ADDR_W-1:0] r_miss_addr;
    logic [31:0]       r_hit_count;
    logic [31:0]       r_miss_count;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_fill_idx;
    logic [TAG_W-1:0]  w_fill_tag;
    logic              w_lookup_hit;
    logic              w_miss;
    logic              w_fill;
    logic              w_unused;

    assign w_idx        = imemaddr[IDX_W+1:2];
    assign w_tag        = imemaddr[ADDR_W-1:IDX_W+2];
    assign w_fill_idx   = r_miss_addr[IDX_W+1:2];
    assign w_fill_tag   = r_miss_addr[ADDR_W-1:IDX_W+2];
    assign w_lookup_hit = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_unused     = ^imemaddr[1:0];

    // Data is presented regardless of hit; consumers qualify it with ihit.
    assign imemload   = r_data[w_idx];
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    always_comb begin
        w_state_d = r_state;
        ihit      = 1'b0;
        iREN      = 1'b0;
        iaddr     = '0;
        w_miss    = 1'b0;
        w_fill    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_lookup_hit) begin
                    ihit = 1'b1;
                end else if (imemREN) begin
                    w_miss    = 1'b1;
                    w_state_d = StFetch;
                end
            end
            StFetch: begin
                iREN  = 1'b1;
                iaddr = r_miss_addr;
                if (!iwait) begin
                    w_fill    = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= StIdle;
            r_valid      <= '0;
            r_miss_addr  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_miss) begin
                r_miss_addr <= {imemaddr[ADDR_W-1:2], 2'b00};
                if (r_miss_count != 32'hFFFF_FFFF) begin
                    r_miss_count <= r_miss_count + 32'd1;
                end
            end
            if (ihit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays carry no reset; a reset during a fetch must not commit the fill.
    always_ff @(posedge CLK) begin
        if (w_fill && !RST) begin
            r_data[w_fill_idx] <= iload;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios followed by random traffic,
// all compared cycle by cycle against a behavioural model of the cache.
module tb_icache_responder;

    localparam int unsigned SETS = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_errors = 0;
    bit do_check = 1'b0;

    // Behavioural model: frames keyed by index, each remembering the full word address it holds.
    bit          m_valid [SETS];
    logic [29:0] m_word  [SETS];
    logic [31:0] m_data  [SETS];
    bit          m_busy;
    logic [31:0] m_miss_addr;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    icache_responder #(
        .SETS   (SETS),
        .ADDR_W (32)
    ) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h2401_0005;
            32'h0000_0004: return 32'hAAAA_AAAA;
            32'h0000_0044: return 32'hBBBB_BBBB;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
    task automatic step(input bit rst, input bit ren, input logic [31:0] addr, input bit wt);
        int  idx;
        bit  exp_hit;
        RST      = rst;
        imemREN  = ren;
        imemaddr = addr;
        iwait    = wt;
        iload    = m_busy ? mem_word(m_miss_addr) : 32'hDEAD_BEEF;
        #2;
        idx     = int'(addr[5:2]);
        exp_hit = !m_busy && ren && m_valid[idx] && (m_word[idx] == addr[31:2]);
        if (do_check) begin
            check("ihit", {31'b0, ihit}, {31'b0, exp_hit});
            check("iREN", {31'b0, iREN}, {31'b0, m_busy});
            check("iaddr", iaddr, m_busy ? m_miss_addr : 32'h0);
            check("hit_count", hit_count, m_hits);
            check("miss_count", miss_count, m_misses);
            if (exp_hit) check("imemload", imemload, m_data[idx]);
        end
        if (rst) begin
            for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
            m_busy   = 1'b0;
            m_hits   = 32'h0;
            m_misses = 32'h0;
        end else if (m_busy) begin
            if (!wt) begin
                idx            = int'(m_miss_addr[5:2]);
                m_valid[idx]   = 1'b1;
                m_word[idx]    = m_miss_addr[31:2];
                m_data[idx]    = mem_word(m_miss_addr);
                m_busy         = 1'b0;
            end
        end else if (exp_hit) begin
            if (m_hits != 32'hFFFF_FFFF) m_hits++;
        end else if (ren) begin
            m_miss_addr = {addr[31:2], 2'b00};
            if (m_misses != 32'hFFFF_FFFF) m_misses++;
            m_busy = 1'b1;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        m_busy      = 1'b0;
        m_miss_addr = 32'h0;
        m_hits      = 32'h0;
        m_misses    = 32'h0;
        @(posedge CLK);
        #1;
        step(1, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        do_check = 1'b1;

        // Cold miss with three wait cycles, then re-hits.
        step(0, 1, 32'h40, 1);
        repeat (3) step(0, 1, 32'h40, 1);
        step(0, 1, 32'h40, 0);
        repeat (4) step(0, 1, 32'h40, 1);
        check("hit_count_after_rehit", hit_count, 32'd4);

        // Conflict eviction on index 1.
        step(0, 1, 32'h04, 0);
        step(0, 1, 32'h04, 0);
        step(0, 1, 32'h04, 0);
        step(0, 1, 32'h44, 0);
        step(0, 1, 32'h44, 0);
        step(0, 1, 32'h44, 0);
        step(0, 1, 32'h04, 0);
        check("evict_iaddr", iaddr, 32'h04);
        check("evict_miss_count", miss_count, 32'd4);
        step(0, 1, 32'h04, 0);
        step(0, 1, 32'h04, 0);

        // Address change while a fetch is outstanding.
        step(0, 1, 32'h100, 1);
        step(0, 1, 32'h200, 1);
        step(0, 0, 32'h200, 1);
        step(0, 1, 32'h200, 0);
        step(0, 1, 32'h200, 0);
        step(0, 1, 32'h200, 0);
        step(0, 1, 32'h200, 1);
        step(0, 1, 32'h100, 1);

        // Reset while fetching abandons the fill.
        step(0, 1, 32'h80, 1);
        step(1, 1, 32'h80, 0);
        check("rst_iren", {31'b0, iREN}, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        step(0, 1, 32'h80, 1);
        step(0, 1, 32'h80, 0);
        step(0, 1, 32'h80, 0);

        // No request means no activity; byte offsets select the same word.
        for (int i = 0; i < 4; i++) step(0, 0, $urandom, $urandom_range(0, 1) == 1);
        step(0, 1, 32'h40, 0);
        step(0, 1, 32'h40, 0);
        step(0, 1, 32'h43, 0);
        check("byte_offset_load", imemload, 32'h2401_0005);

        // Random traffic over a small address pool so hits, misses and conflicts all occur.
        for (int i = 0; i < 3000; i++) begin
            a = ({24'h0, 8'($urandom_range(0, 127))} << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a[31] = 1'b1;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 8, a,
                 $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
